// File: rtl/bcd_conversion_controller.sv
// bcd_conversion_controller
//   Sequencer for a 4-digit serial binary-to-BCD converter. An operand is
//   accepted over a valid/ready handshake, shifted into the converter MSB
//   first (one bit per clock), and the converter's BCD output plus an
//   overflow flag are captured into output registers. The result is then
//   offered over an output valid/ready handshake.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  operand handshake (ready only while idle)
//   in_bin          unsigned operand, BIN_WIDTH bits
//   out_valid/ready result handshake
//   out_bcd/out_ovf registered result; ovf set when operand > 9999
//   busy            conversion in progress (shifting or capturing)
//   conv_si/ci/rst  drive the converter's serial in, carry in, clear
//   conv_bcd/so     converter's BCD output and digit-3 carry out
module bcd_conversion_controller #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] in_bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_bcd,
  output logic                 out_ovf,
  output logic                 busy,
  output logic                 conv_si,
  output logic                 conv_ci,
  output logic                 conv_rst,
  input  logic [15:0]          conv_bcd,
  input  logic                 conv_so
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(BIN_WIDTH - 1);

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] sh_q, sh_d;
  logic                 sticky_q, sticky_d;
  logic [15:0]          bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh_d     = in_bin;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d     = sh_q << 1;
        cnt_d    = cnt_q + 5'd1;
        // conv_so is the carry from the previous shift; collect every one
        sticky_d = sticky_q | conv_so;
        if (cnt_q == LAST_BIT) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        bcd_d   = conv_bcd;
        // conv_so now holds the carry produced by the final shift
        ovf_d   = sticky_q | conv_so;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_CAPTURE);
  // Converter is held clear whenever it is not being fed bits, so the
  // first shift always starts from zero.
  assign conv_rst  = (state_q != S_SHIFT);
  assign conv_si   = (state_q == S_SHIFT) && sh_q[BIN_WIDTH-1];
  assign conv_ci   = 1'b0;
  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;

endmodule
